// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: op encoding, FSM states and
// the byte-enable helper used by the lane aligner.
package lsu_pkg;

  localparam logic [2:0] OP_NONE = 3'd0;
  localparam logic [2:0] OP_LB   = 3'd1;
  localparam logic [2:0] OP_LH   = 3'd2;
  localparam logic [2:0] OP_LW   = 3'd3;
  localparam logic [2:0] OP_SB   = 3'd4;
  localparam logic [2:0] OP_SH   = 3'd5;
  localparam logic [2:0] OP_SW   = 3'd6;

  // Widest byte-enable vector the helper can produce (DATA_W up to 512).
  localparam int BE_MAX = 64;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } lsu_state_e;

  function automatic logic op_is_load(input logic [2:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW);
  endfunction

  function automatic logic op_is_store(input logic [2:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  // Byte enables for a store of the given op at byte lane 'lane' in a word
  // of 'nb' bytes. Loads and non-memory ops enable nothing.
  function automatic logic [BE_MAX-1:0] byte_en(input logic [2:0] op,
                                                input logic [5:0] lane,
                                                input int nb);
    logic [BE_MAX-1:0] be;
    case (op)
      OP_SB:   be = {{(BE_MAX-1){1'b0}}, 1'b1} << lane;
      OP_SH:   be = {{(BE_MAX-2){1'b0}}, 2'b11} << lane;
      OP_SW:   be = ~({BE_MAX{1'b1}} << nb);
      default: be = '0;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: store data replication, byte enables and
// load-lane extraction with sign/zero extension.
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int NB = DATA_W / 8,
  localparam int LANE_W = $clog2(DATA_W / 8)
) (
  input  logic [2:0]        op,
  input  logic              is_unsigned,
  input  logic [LANE_W-1:0] lane,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic [NB-1:0]     be,
  output logic [DATA_W-1:0] wdata_rep,
  output logic [DATA_W-1:0] rdata_ext
);

  logic [BE_MAX-1:0] be_all;
  logic [DATA_W-1:0] rdata_shift;

  // Byte enables from the shared helper, trimmed to this word width.
  always_comb begin
    be_all = byte_en(op, 6'(lane), NB);
  end

  assign be = be_all[NB-1:0];

  if (NB < BE_MAX) begin : g_be_hi
    logic unused_be_hi;
    assign unused_be_hi = ^be_all[BE_MAX-1:NB];
  end

  // Replicate the right-aligned store datum across every lane so the
  // byte enables alone select where it lands.
  always_comb begin
    wdata_rep = '0;
    case (op)
      OP_SB:   wdata_rep = {NB{wdata[7:0]}};
      OP_SH:   wdata_rep = {(NB/2){wdata[15:0]}};
      OP_SW:   wdata_rep = wdata;
      default: wdata_rep = '0;
    endcase
  end

  // Bring the addressed lane down to bit 0, then mask and extend. Full-word
  // loads are always lane 0, so the shift leaves them untouched.
  always_comb begin
    rdata_shift = rdata >> {lane, 3'b000};
    rdata_ext   = '0;
    case (op)
      OP_LB: rdata_ext = {{(DATA_W-8){~is_unsigned & rdata_shift[7]}}, rdata_shift[7:0]};
      OP_LH: rdata_ext = {{(DATA_W-16){~is_unsigned & rdata_shift[15]}}, rdata_shift[15:0]};
      OP_LW: rdata_ext = rdata_shift;
      default: rdata_ext = '0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_wb.sv
// Load/store unit with MEM/WB output register. Drives a variable-latency
// data memory and stalls the pipeline while an access is outstanding.
// Optional feature macro: LSU_TIMEOUT_EN (ack timeout of TIMEOUT_CYC cycles).
//
// Memory handshake: mem_req is held high, with mem_we/mem_be/mem_addr/
// mem_wdata stable, until the cycle in which mem_ack is high; that cycle
// completes the access (mem_rdata is sampled with it). mem_ack may arrive in
// the same cycle mem_req first rises. mem_ack outside a request is ignored.
module lsu_mem_wb
  import lsu_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int REG_W       = 5,
  parameter int WB_W        = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [2:0]          in_op,
  input  logic                in_unsigned,
  input  logic [ADDR_W-1:0]   in_addr,
  input  logic [DATA_W-1:0]   in_wdata,
  input  logic [WB_W-1:0]     in_wb_bus,
  input  logic [REG_W-1:0]    in_write_reg,
  input  logic                in_halt,
  output logic                stall,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ack,
  output logic                out_valid,
  output logic [DATA_W-1:0]   out_rdata,
  output logic [ADDR_W-1:0]   out_addr,
  output logic [WB_W-1:0]     out_wb_bus,
  output logic [REG_W-1:0]    out_write_reg,
  output logic                out_halt,
  output logic                out_fault
);

  localparam int NB     = DATA_W / 8;
  localparam int LANE_W = $clog2(NB);

  lsu_state_e state_q, state_d;

  // Instruction captured when an access has to wait for its ack.
  logic [2:0]        op_q;
  logic              uns_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [NB-1:0]     be_q;
  logic              we_q;
  logic [WB_W-1:0]   wb_q;
  logic [REG_W-1:0]  reg_q;
  logic              halt_q;
  logic              capture;

  // Next values of the MEM/WB output register.
  logic              ov_d, ofault_d, ohalt_d;
  logic [DATA_W-1:0] ordata_d;
  logic [ADDR_W-1:0] oaddr_d;
  logic [WB_W-1:0]   owb_d;
  logic [REG_W-1:0]  oreg_d;

  logic in_mem, in_mis, timed_out;
  logic [2:0]        al_op;
  logic              al_uns;
  logic [LANE_W-1:0] al_lane;
  logic [NB-1:0]     al_be;
  logic [DATA_W-1:0] al_wdata, al_rdata;

  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
  endfunction

  assign in_mem = op_is_load(in_op) || op_is_store(in_op);

  // An access is misaligned when any address bit below its size is set.
  always_comb begin
    in_mis = 1'b0;
    case (in_op)
      OP_LH, OP_SH: in_mis = in_addr[0];
      OP_LW, OP_SW: in_mis = |in_addr[LANE_W-1:0];
      default:      in_mis = 1'b0;
    endcase
  end

  // The aligner sees the live instruction in IDLE and the captured one in WAIT.
  assign al_op   = (state_q == ST_WAIT) ? op_q : in_op;
  assign al_uns  = (state_q == ST_WAIT) ? uns_q : in_unsigned;
  assign al_lane = (state_q == ST_WAIT) ? addr_q[LANE_W-1:0] : in_addr[LANE_W-1:0];

  lsu_lane_align #(.DATA_W(DATA_W)) u_align (
    .op          (al_op),
    .is_unsigned (al_uns),
    .lane        (al_lane),
    .wdata       (in_wdata),
    .rdata       (mem_rdata),
    .be          (al_be),
    .wdata_rep   (al_wdata),
    .rdata_ext   (al_rdata)
  );

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] to_cnt_q;

  // Count WAIT cycles; the last allowed cycle without an ack gives up.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  to_cnt_q <= '0;
    else if (state_q == ST_WAIT) to_cnt_q <= to_cnt_q + 1'b1;
    else                        to_cnt_q <= '0;
  end

  assign timed_out = (state_q == ST_WAIT) && !mem_ack &&
                     (to_cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
  assign timed_out = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state, memory interface, stall and output-register next values.
  // Reset is folded in so an asserted reset drops mem_req at once.
  always_comb begin
    state_d   = state_q;
    stall     = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    capture   = 1'b0;
    ov_d      = 1'b0;
    ofault_d  = 1'b0;
    ordata_d  = '0;
    oaddr_d   = '0;
    owb_d     = '0;
    oreg_d    = '0;
    ohalt_d   = 1'b0;
    if (!reset) begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            if (in_mem && !in_mis) begin
              mem_req   = 1'b1;
              mem_we    = op_is_store(in_op);
              mem_be    = al_be;
              mem_addr  = word_addr(in_addr);
              mem_wdata = al_wdata;
              if (mem_ack) begin
                ov_d     = 1'b1;
                ordata_d = al_rdata;
                oaddr_d  = in_addr;
                owb_d    = in_wb_bus;
                oreg_d   = in_write_reg;
                ohalt_d  = in_halt;
              end else begin
                stall   = 1'b1;
                capture = 1'b1;
                state_d = ST_WAIT;
              end
            end else begin
              ov_d     = 1'b1;
              ofault_d = in_mis;
              oaddr_d  = in_addr;
              owb_d    = in_mis ? '0 : in_wb_bus;
              oreg_d   = in_write_reg;
              ohalt_d  = in_halt;
            end
          end
        end
        ST_WAIT: begin
          mem_req   = 1'b1;
          mem_we    = we_q;
          mem_be    = be_q;
          mem_addr  = word_addr(addr_q);
          mem_wdata = wdata_q;
          stall     = 1'b1;
          if (mem_ack) begin
            stall    = 1'b0;
            ov_d     = 1'b1;
            ordata_d = al_rdata;
            oaddr_d  = addr_q;
            owb_d    = wb_q;
            oreg_d   = reg_q;
            ohalt_d  = halt_q;
            state_d  = ST_IDLE;
          end else if (timed_out) begin
            stall    = 1'b0;
            ov_d     = 1'b1;
            ofault_d = 1'b1;
            oaddr_d  = addr_q;
            oreg_d   = reg_q;
            ohalt_d  = halt_q;
            state_d  = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Capture the instruction and its shaped memory request on entry to WAIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q    <= OP_NONE;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      wb_q    <= '0;
      reg_q   <= '0;
      halt_q  <= 1'b0;
    end else if (capture) begin
      op_q    <= in_op;
      uns_q   <= in_unsigned;
      addr_q  <= in_addr;
      wdata_q <= al_wdata;
      be_q    <= al_be;
      we_q    <= op_is_store(in_op);
      wb_q    <= in_wb_bus;
      reg_q   <= in_write_reg;
      halt_q  <= in_halt;
    end
  end

  // MEM/WB output register: a completion or a bubble every cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid     <= 1'b0;
      out_fault     <= 1'b0;
      out_rdata     <= '0;
      out_addr      <= '0;
      out_wb_bus    <= '0;
      out_write_reg <= '0;
      out_halt      <= 1'b0;
    end else begin
      out_valid     <= ov_d;
      out_fault     <= ofault_d;
      out_rdata     <= ordata_d;
      out_addr      <= oaddr_d;
      out_wb_bus    <= owb_d;
      out_write_reg <= oreg_d;
      out_halt      <= ohalt_d;
    end
  end

endmodule

// File: doc/lsu_mem_wb.md
Name: lsu_mem_wb

Overview:
Parametrised load/store unit plus MEM/WB pipeline register; successor to the fixed 32-bit, single-cycle memory stage.
- Drives an external data memory through a req/ack handshake with variable latency, and stalls the pipeline while an access is outstanding.
- Stores use true byte-lane enables; loads select the addressed lane and sign- or zero-extend it.
- Misaligned accesses are detected and suppressed.
- Sits between the EX/MEM latch and write-back; branch resolution stays outside this block.

Parameters:
DATA_W, 32, data width in bits; power of two, ≥16.
ADDR_W, 32, byte-address width.
REG_W, 5, destination register index width.
WB_W, 2, write-back control bus width.
TIMEOUT_CYC, 64, ack timeout in cycles; used only with LSU_TIMEOUT_EN.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high
in_valid  in  1  an instruction is present in this stage
in_op  in  3  0=NONE 1=LB 2=LH 3=LW 4=SB 5=SH 6=SW; 7 is treated as NONE
in_unsigned  in  1  zero-extend loads
in_addr  in  ADDR_W  effective byte address
in_wdata  in  DATA_W  store data, right-aligned
in_wb_bus  in  WB_W  write-back controls
in_write_reg  in  REG_W  destination register
in_halt  in  1  halt marker
stall  out  1  upstream must hold its inputs
mem_req  out  1  memory request
mem_we  out  1  1 = write
mem_be  out  DATA_W/8  byte enables
mem_addr  out  ADDR_W  word-aligned address (low bits zero)
mem_wdata  out  DATA_W  lane-shifted store data
mem_rdata  in  DATA_W  read data; valid with mem_ack
mem_ack  in  1  access complete
out_valid  out  1  WB-stage valid
out_rdata  out  DATA_W  extended load result
out_addr  out  ADDR_W  registered in_addr (ALU result path)
out_wb_bus  out  WB_W  write-back controls; forced 0 on fault
out_write_reg  out  REG_W  registered destination
out_halt  out  1  registered halt marker
out_fault  out  1  misaligned (or timed-out) access

Behaviour:
Reset:
- All outputs and state clear to 0; FSM goes to IDLE.
- Reset asserted mid-access drops mem_req immediately (asynchronous); a late ack is ignored.

FSM has two states, IDLE and WAIT.
- IDLE, in_valid with NONE, or a misaligned access:
  - Output register loads on the next edge; 1-cycle latency; stall=0.
  - Misaligned means LH with addr[0]=1, or LW with addr[1:0]≠0 (generalised: any low address bit below the access size).
  - On a fault: out_fault=1, out_wb_bus=0, no memory request.
- IDLE, aligned load/store:
  - mem_req asserts combinationally in the same cycle; stall=1 combinationally.
  - Transition to WAIT.
- WAIT:
  - mem_req, mem_we, mem_be, mem_addr and mem_wdata are held stable from internal capture registers; stall=1.
  - On mem_ack: output register loads; stall deasserts in the same cycle (combinationally from mem_ack); return to IDLE.
  - An ack in the same cycle as the request (the IDLE cycle) is legal and completes the access with zero wait states.
- The block ignores inputs while stall=1; upstream holds them.
- out_valid=0 when idle with no instruction, and during WAIT (bubble).
- out_halt propagates only when the instruction completes.

Store lanes (lane = addr[1:0]):
- SB: be = 1<<lane; wdata byte replicated across all lanes.
- SH: be = 0b11<<lane; halfword replicated.
- SW: all ones.

Load extraction:
- Shift mem_rdata right by lane*8, mask to 8 or 16 bits, then extend by sign or zero per in_unsigned.
- LW passes the word through unchanged.
- Stores produce out_rdata=0.

Optional Feature:
LSU_TIMEOUT_EN
- Defined: a counter runs in WAIT. If no ack arrives by TIMEOUT_CYC cycles:
  - drop mem_req;
  - complete with out_fault=1 and out_wb_bus=0;
  - return to IDLE.
- Undefined: the block waits indefinitely; no counter logic is present.

Decomposition:
- Package lsu_pkg: op encoding localparams, FSM state encoding, and a function byte_en(op, lane).
- One natural sub-module, lsu_lane_align: combinational store replication, byte enables and load extraction/extension, parametrised by DATA_W.

Test Plan:
- SB addr=0x13, wdata=0x000000AB, ack after 2 cycles -> mem_be=0b1000, mem_addr=0x10, mem_wdata=0xABABABAB, stall high for 3 cycles, out_valid pulse.
- LH signed addr=0x22, mem_rdata=0x8001_0000 -> out_rdata=0xFFFF8001; same with in_unsigned=1 -> 0x00008001.
- LW addr=0x06 -> no mem_req, out_fault=1, out_wb_bus=0, 1-cycle latency, stall never high.
- Zero-wait LB addr=0x01, ack in the request cycle, mem_rdata=0x0000_7F00 -> out_rdata=0x0000007F next edge, stall=0 throughout.
- Reset asserted in WAIT -> mem_req=0 immediately; ack one cycle later has no effect; all outputs 0.
- With LSU_TIMEOUT_EN and TIMEOUT_CYC=4, never ack -> mem_req drops after 4 WAIT cycles, out_fault=1, FSM back to IDLE.
